// File: rtl/tape_buf_reader.sv
// Tape player byte-read front end: periodic read window, sequential prefetch
// window over the SDRAM tape image, and window stretching on a miss.
module tape_buf_reader #(
  parameter logic [24:0] BASE_ADDR   = 25'h0000000,
  parameter int          SLOT_PERIOD = 16,
  parameter int          EN_WIDTH    = 8,
  parameter int          DEPTH       = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        flush,
  output logic        tape_rd_en,
  input  logic        tape_rd,
  input  logic [24:0] tape_addr,
  output logic [7:0]  tape_din,
  output logic        mem_req,
  output logic [24:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_dout,
  output logic        busy
);

  localparam int IW = $clog2(DEPTH);
  localparam int VW = IW + 1;
  localparam int SW = $clog2(SLOT_PERIOD);
  localparam logic [SW-1:0] LAST_SLOT   = SW'(SLOT_PERIOD - 1);
  localparam logic [SW-1:0] SAMPLE_SLOT = SW'(EN_WIDTH - 1);
  localparam logic [SW-1:0] EN_SLOTS    = SW'(EN_WIDTH);
  localparam logic [VW-1:0] FULL        = VW'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t        r_state, w_stateNext;
  logic [24:0]   r_off, w_offNext;
  logic          r_started;
  logic [SW-1:0] r_slot;
  logic [24:0]   r_wbase;
  logic [VW-1:0] r_vcnt;
  logic          r_pend;
  logic [7:0]    r_din;
  logic [7:0]    r_mem [DEPTH];

  logic [24:0]   w_diff;
  logic          w_sample, w_hit, w_miss, w_ackFetch, w_deliver, w_store, w_freeze;
  logic [VW-1:0] w_used, w_dec, w_inc;

  // Entries live at slot offset[IW-1:0]; a contiguous window of at most
  // DEPTH offsets never aliases, so no read pointer is needed.
  always_comb begin
    w_diff     = tape_addr - r_wbase;
    w_sample   = r_started && (r_slot == SAMPLE_SLOT) && tape_rd && !r_pend && !flush;
    w_hit      = w_sample && (w_diff < 25'(r_vcnt));
    w_miss     = w_sample && !w_hit;
    w_ackFetch = (r_state == FETCH) && mem_ack;
    w_deliver  = w_ackFetch && !flush && (r_pend || (w_miss && (r_off == tape_addr)));
    w_store    = w_ackFetch && !flush && !r_pend && !w_miss;
    w_freeze   = (r_slot == SAMPLE_SLOT) && !w_deliver && !flush && (w_miss || r_pend);
    w_used     = w_diff[VW-1:0] + VW'(1);
    w_dec      = w_hit ? w_used : '0;
    w_inc      = w_store ? VW'(1) : '0;
  end

  assign tape_rd_en = r_started && (r_slot < EN_SLOTS);
  assign tape_din   = r_din;
  assign mem_addr   = BASE_ADDR + r_off;
  assign busy       = mem_req || r_pend;

  // Slot counter plus window bookkeeping; flush beats delivery beats miss.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_started <= 1'b0;
      r_slot    <= '0;
      r_wbase   <= '0;
      r_vcnt    <= '0;
      r_pend    <= 1'b0;
      r_din     <= '0;
    end else begin
      r_started <= 1'b1;
      if (r_started && !w_freeze)
        r_slot <= (r_slot == LAST_SLOT) ? '0 : r_slot + SW'(1);
      if (flush) begin
        r_vcnt <= '0;
        r_pend <= 1'b0;
      end else if (w_deliver) begin
        r_din   <= mem_dout;
        r_wbase <= r_off + 25'd1;
        r_vcnt  <= '0;
        r_pend  <= 1'b0;
      end else if (w_miss) begin
        r_pend  <= 1'b1;
        r_vcnt  <= '0;
        r_wbase <= tape_addr;
      end else begin
        if (w_hit) begin
          r_din   <= r_mem[tape_addr[IW-1:0]];
          r_wbase <= tape_addr + 25'd1;
        end
        r_vcnt <= r_vcnt - w_dec + w_inc;
      end
    end
  end

  // A prefetch always lands at wbase+vcnt, which stays the next slot even
  // when a hit retires entries in the same cycle.
  always_ff @(posedge clk_sys) begin
    if (w_store)
      r_mem[r_off[IW-1:0]] <= mem_dout;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_off   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_off   <= w_offNext;
    end
  end

  // An outstanding request is never withdrawn; unwanted data drains instead.
  always_comb begin
    w_stateNext = r_state;
    w_offNext   = r_off;
    mem_req     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!flush && !w_miss) begin
          if (r_pend) begin
            w_stateNext = FETCH;
            w_offNext   = r_wbase;
          end else if (r_vcnt < FULL) begin
            w_stateNext = FETCH;
            w_offNext   = r_wbase + 25'(r_vcnt);
          end
        end
      end
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack)
          w_stateNext = IDLE;
        else if (flush || (w_miss && (r_off != tape_addr)))
          w_stateNext = DRAIN;
      end
      DRAIN: begin
        mem_req = 1'b1;
        if (mem_ack)
          w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tape_buf_reader.sv
// Directed bench for tape_buf_reader: a player model, an SDRAM responder with
// programmable latency and a table of read vectors, plus flush/reset corners.
module tb_tape_buf_reader;

  localparam logic [24:0] BASE = 25'h1FFFFFE;

  logic        clk_sys, reset, flush;
  logic        tape_rd_en, tape_rd;
  logic [24:0] tape_addr;
  logic [7:0]  tape_din;
  logic        mem_req, mem_ack, busy;
  logic [24:0] mem_addr;
  logic [7:0]  mem_dout;

  int          nChecks = 0;
  int          nFails  = 0;
  int          latency = 2;
  int          waitCnt = 0;
  logic        prevReq = 1'b0;
  logic [24:0] reqQ[$];

  typedef struct {
    logic [24:0] off;
    int          lat;
    int          expWidth;
    logic [7:0]  expDin;
    logic [24:0] expFirst;
    int          expReqs;
  } vec_t;

  vec_t vecs[12];

  tape_buf_reader #(.BASE_ADDR(BASE)) dut (
    .clk_sys(clk_sys), .reset(reset), .flush(flush),
    .tape_rd_en(tape_rd_en), .tape_rd(tape_rd), .tape_addr(tape_addr),
    .tape_din(tape_din), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_dout(mem_dout), .busy(busy)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  function automatic logic [7:0] img(input logic [24:0] o);
    return o[7:0] ^ o[15:8] ^ 8'hA5;
  endfunction

  // SDRAM responder: logs each new request offset, acks after 'latency' cycles.
  initial begin
    logic [24:0] off;
    mem_ack  = 1'b0;
    mem_dout = 8'h00;
    forever begin
      @(negedge clk_sys);
      mem_ack = 1'b0;
      off = mem_addr - BASE;
      if (mem_req && !prevReq) reqQ.push_back(off);
      prevReq = mem_req;
      if (mem_req) begin
        if (waitCnt >= latency) begin
          mem_ack  = 1'b1;
          mem_dout = img(off);
          waitCnt  = 0;
        end else begin
          waitCnt++;
        end
      end else begin
        waitCnt = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic waitQuiet();
    int low = 0;
    int n   = 0;
    while (low < 4 && n < 3000) begin
      tick();
      low = mem_req ? 0 : low + 1;
      n++;
    end
    checkOutput("memQuiet", low >= 4, 1);
  endtask

  task automatic waitReq();
    int n = 0;
    while (reqQ.size() == 0 && n < 100) begin
      tick();
      n++;
    end
    checkOutput("reqSeen", reqQ.size() > 0, 1);
  endtask

  // Player model: waits for a fresh window, requests 'off', measures how long
  // the window stays open and captures the byte once it has fallen.
  task automatic applyStimulus(input logic [24:0] off, output int width, output logic [7:0] din,
                               output bit timedOut);
    int n = 0;
    timedOut = 0;
    width    = 0;
    tape_rd  = 1'b0;
    while (tape_rd_en && n < 300) begin tick(); n++; end
    while (!tape_rd_en && n < 300) begin tick(); n++; end
    if (n >= 300) timedOut = 1;
    tape_rd   = 1'b1;
    tape_addr = off;
    width     = 1;
    n         = 0;
    while (n < 300) begin
      tick();
      n++;
      if (!tape_rd_en) break;
      width++;
    end
    if (n >= 300) timedOut = 1;
    din     = tape_din;
    tape_rd = 1'b0;
  endtask

  initial begin
    int          width;
    logic [7:0]  din;
    bit          to;
    bit          held, sawAck, anyReq;
    int          qn;
    logic [24:0] e;

    vecs[0]  = '{25'h0000000, 2,  8, 8'hA5, 25'h0000004, 1};
    vecs[1]  = '{25'h0000001, 2,  8, 8'hA4, 25'h0000005, 1};
    vecs[2]  = '{25'h0000002, 2,  8, 8'hA7, 25'h0000006, 1};
    vecs[3]  = '{25'h0000003, 2,  8, 8'hA6, 25'h0000007, 1};
    vecs[4]  = '{25'h0000100, 20, 30, 8'hA4, 25'h0000100, 5};
    vecs[5]  = '{25'h0000009, 2, 12, 8'hAC, 25'h0000009, 5};
    vecs[6]  = '{25'h000000C, 2,  8, 8'hA9, 25'h000000E, 3};
    vecs[7]  = '{25'h00001FF, 2, 12, 8'h5B, 25'h00001FF, 5};
    vecs[8]  = '{25'h0000050, 2, 12, 8'hF5, 25'h0000050, 5};
    vecs[9]  = '{25'h0000051, 2,  8, 8'hF4, 25'h0000055, 1};
    vecs[10] = '{25'h1FFFFFF, 2, 12, 8'hA5, 25'h1FFFFFF, 5};
    vecs[11] = '{25'h0000001, 2,  8, 8'hA4, 25'h0000004, 2};

    reset     = 1'b1;
    flush     = 1'b1;
    tape_rd   = 1'b0;
    tape_addr = '0;
    repeat (3) tick();
    checkOutput("rstRdEn",   tape_rd_en, 0);
    checkOutput("rstDin",    tape_din,   0);
    checkOutput("rstMemReq", mem_req,    0);
    checkOutput("rstMemAddr", mem_addr,  BASE);
    checkOutput("rstBusy",   busy,       0);

    reset = 1'b0;
    repeat (10) tick();
    checkOutput("noReqDuringFlush", reqQ.size(), 0);
    flush = 1'b0;
    waitQuiet();
    checkOutput("initReqCount", reqQ.size(), 4);
    for (int j = 0; j < 4; j++)
      if (j < reqQ.size()) checkOutput("initReqOff", reqQ[j], j);

    for (int i = 0; i < 12; i++) begin
      latency = vecs[i].lat;
      reqQ.delete();
      applyStimulus(vecs[i].off, width, din, to);
      checkOutput("readTimeout", to, 0);
      checkOutput($sformatf("width[%0d]", i), width, vecs[i].expWidth);
      checkOutput($sformatf("din[%0d]", i), din, vecs[i].expDin);
      waitQuiet();
      checkOutput($sformatf("reqCount[%0d]", i), reqQ.size(), vecs[i].expReqs);
      for (int j = 0; j < vecs[i].expReqs; j++) begin
        e = vecs[i].expFirst + 25'(j);
        if (j < reqQ.size()) checkOutput($sformatf("reqOff[%0d.%0d]", i, j), reqQ[j], e);
      end
    end

    // Flush while a prefetch is outstanding: request held to ack, data dropped.
    latency = 10;
    reqQ.delete();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    waitReq();
    if (reqQ.size() > 0) checkOutput("flushRefetch", reqQ[0], 25'h2);
    flush  = 1'b1;
    held   = 1'b1;
    sawAck = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (!mem_req) held = 1'b0;
      if (mem_ack) begin sawAck = 1'b1; break; end
      tick();
    end
    checkOutput("flushReqHeld", held, 1);
    checkOutput("flushAckSeen", sawAck, 1);
    tick();
    qn     = reqQ.size();
    anyReq = 1'b0;
    repeat (20) begin
      tick();
      if (mem_req) anyReq = 1'b1;
    end
    checkOutput("flushNoReq", anyReq, 0);
    checkOutput("flushNoLog", reqQ.size(), qn);
    checkOutput("flushBusy", busy, 0);
    latency = 2;
    reqQ.delete();
    flush = 1'b0;
    waitReq();
    if (reqQ.size() > 0) checkOutput("flushDataDropped", reqQ[0], 25'h2);
    waitQuiet();

    // Reset while a miss is stretching the window.
    latency = 30;
    qn = 0;
    while (tape_rd_en && qn < 100) begin tick(); qn++; end
    while (!tape_rd_en && qn < 100) begin tick(); qn++; end
    tape_rd   = 1'b1;
    tape_addr = 25'h300;
    repeat (12) tick();
    checkOutput("stretchEn", tape_rd_en, 1);
    checkOutput("stretchBusy", busy, 1);
    reset   = 1'b1;
    tape_rd = 1'b0;
    tick();
    checkOutput("midRstRdEn", tape_rd_en, 0);
    checkOutput("midRstMemReq", mem_req, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstDin", tape_din, 0);
    latency = 2;
    reqQ.delete();
    reset = 1'b0;
    qn = 0;
    while (!tape_rd_en && qn < 100) begin tick(); qn++; end
    width = 0;
    while (tape_rd_en && qn < 200) begin width++; tick(); qn++; end
    checkOutput("postRstWidth", width, 8);
    waitQuiet();
    checkOutput("postRstReqCount", reqQ.size(), 4);
    if (reqQ.size() > 0) checkOutput("postRstFirstReq", reqQ[0], 25'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/tape_buf_reader.md
Name: tape_buf_reader

Overview:
- Sits directly downstream of the tape player's byte-read port and upstream of the SDRAM arbiter port that holds the downloaded tape image.
- Generates the periodic read window (tape_rd_en) the player samples on its falling edge, and services each read request from a small sequential prefetch window.
- On a miss it stretches the window until memory returns data, so the player always samples a valid byte.

Parameters:
- BASE_ADDR, 25'h0000000, SDRAM byte address of tape image offset 0.
- SLOT_PERIOD, 16, clk_sys cycles per read window period (>= EN_WIDTH+2).
- EN_WIDTH, 8, nominal high time of tape_rd_en in cycles (>= 2).
- DEPTH, 4, prefetch window entries (power of 2, 2..16).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  invalidate window (tape download start / new image); level or pulse.
- tape_rd_en  out  1  read window to player; player samples tape_din on its falling edge.
- tape_rd  in  1  player read request; valid only while tape_rd_en=1.
- tape_addr  in  25  requested byte offset; stable while tape_rd=1.
- tape_din  out  8  byte for the current request.
- mem_req  out  1  SDRAM read request; held until mem_ack.
- mem_addr  out  25  BASE_ADDR + offset, modulo 2^25.
- mem_ack  in  1  one-cycle pulse, mem_dout valid the same cycle.
- mem_dout  in  8  SDRAM read data.
- busy  out  1  high while mem_req high or a miss is pending.

Behaviour:
- Reset values: tape_rd_en=0, tape_din=0, mem_req=0, mem_addr=BASE_ADDR, busy=0, slot counter=0, window empty (wbase=0, vcnt=0).
- Slot counter: counts 0..SLOT_PERIOD-1 and wraps. tape_rd_en=1 while count<EN_WIDTH. The counter freezes at EN_WIDTH-1 while a miss is pending, which stretches the window.
- Request sampling: at count==EN_WIDTH-1 with tape_rd=1, compare tape_addr with the window [wbase, wbase+vcnt) (25-bit modular).
  - Hit: tape_din <= entry(tape_addr) that cycle. Then wbase <= tape_addr+1 and vcnt decrements by (tape_addr-wbase+1). The consumed and skipped entries are dropped. The window falls next cycle.
  - Miss: set pending. Discard the window (vcnt=0, wbase=tape_addr). Fetch tape_addr at the next FSM opportunity. On its mem_ack, drive tape_din=mem_dout, clear pending, unfreeze; tape_rd_en falls the following cycle. The fetched byte is consumed, not stored: wbase <= tape_addr+1.
- tape_rd=0 at sample point: no action; the window falls on schedule.
- tape_din holds its last value between requests.
- FSM states:
  - IDLE: if pending, go to FETCH with offset=wbase. Else if vcnt<DEPTH and ~flush, go to FETCH with offset=wbase+vcnt (prefetch).
  - FETCH: mem_req=1, mem_addr=BASE_ADDR+offset. On mem_ack: mem_req=0. If pending, deliver to the player; else write the entry and increment vcnt. Return to IDLE. Exactly one request is outstanding at a time.
  - DRAIN: entered on flush or window discard while FETCH is outstanding. Keep mem_req until mem_ack, drop the data, then go to IDLE. The request is never withdrawn before ack.
- Miss during an outstanding prefetch: that prefetch's data is discarded via DRAIN unless its offset equals tape_addr. In that case it satisfies the miss directly.
- Hit and prefetch mem_ack in the same cycle: the hit update is applied first. The arriving byte is stored at its absolute offset if still inside the new window, else dropped.
- flush: vcnt=0, pending cleared, tape_din unchanged, slot counter unfrozen. No new prefetch is issued while flush=1.
- Window arithmetic wraps modulo 2^25. vcnt width is log2(DEPTH)+1.
- Asynchronous reset mid-FETCH drops mem_req immediately. The arbiter must tolerate an abandoned request.

Test Plan:
- Sequential read: after flush, with an idle player, exactly 4 mem_req are issued for offsets 0..3. Player then reads 0,1,2,3 → all hits, tape_rd_en high exactly EN_WIDTH=8 cycles each, tape_din = image[0..3], and refills issue for offsets 4..7.
- Cold miss: player reads offset 0x100 with mem_ack delayed 20 cycles → tape_rd_en stays high until the ack cycle+1, and tape_din=image[0x100] at the falling edge.
- Skip-forward hit: window 10..13 valid, read 12 → hit, wbase=13, vcnt=1, and prefetch resumes at offset 14.
- Backward jump: window 0x200..0x203 valid, read 0x50 → miss, window discarded, mem_addr=BASE_ADDR+0x50, and the correct byte is delivered.
- Flush during FETCH: assert flush while mem_req=1 → mem_req stays high until ack, the data is dropped, vcnt=0, and no new request is issued while flush=1.
- Reset mid-stretch: assert reset with a miss pending → next cycle tape_rd_en=0, mem_req=0, busy=0, and after release the first window is a normal 8-cycle window.
